alu_32bit_serial: RTL and testbench

//  Bit-serial counterpart of the parallel 32-bit logic/arith units: processes one operand bit per cycle

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_serial_slice.sv | 33 +++
 rtl/alu_32bit_serial.sv | 121 ++++++++++++
 tb/tb_alu_32bit_serial.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings and serial-unit FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Ops that go through the adder path and produce a meaningful carry.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // Ops that subtract (B inverted, carry seeded to 1).
  function automatic logic is_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: and/or/xor/full-add with optional B inversion.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binvert,
  output logic       y,
  output logic       cout
);

  logic bb;
  logic sum;

  always_comb begin
    bb   = b ^ binvert;
    sum  = a ^ bb ^ cin;
    cout = (a & bb) | (cin & (a ^ bb));
    y    = 1'b0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_ADD,
      ALU_SUB,
      ALU_SLT: y = sum;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_32bit_serial.sv
// Bit-serial ALU: one operand bit per cycle through alu_serial_slice, LSB first.
// Optional overflow output enabled by defining ALU_SERIAL_OVERFLOW_EN.
module alu_32bit_serial
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_SERIAL_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout
);

  alu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [2:0]       op_q;
  logic             carry;
  logic [WIDTH-2:0] sh;

  logic             s_y, s_cout;
  logic             last;
  logic [WIDTH-1:0] sh_full;
  logic             ovf_bit;
  logic [WIDTH-1:0] res_nxt;

  alu_serial_slice u_slice (
    .op      (op_q),
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry),
    .binvert (is_sub(op_q)),
    .y       (s_y),
    .cout    (s_cout)
  );

  // On the final bit the carry flop still holds the carry into the MSB,
  // so overflow and the SLT sign correction come straight from it.
  always_comb begin
    last    = (cnt == CNT_W'(WIDTH - 1));
    sh_full = {s_y, sh};
    ovf_bit = carry ^ s_cout;
    res_nxt = sh_full;
    if (op_q == ALU_SLT)
      res_nxt = {{(WIDTH-1){1'b0}}, s_y ^ ovf_bit};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= '0;
      carry    <= 1'b0;
      sh       <= '0;
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            op_q  <= op;
            cnt   <= '0;
            carry <= is_sub(op);
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sh    <= sh_full[WIDTH-1:1];
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result <= res_nxt;
            zero   <= (res_nxt == '0);
            cout   <= is_arith(op_q) ? s_cout : 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
            overflow <= ((op_q == ALU_ADD) || (op_q == ALU_SUB)) ? ovf_bit : 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_32bit_serial.sv
// Scoreboard testbench for alu_32bit_serial (also builds with ALU_SERIAL_OVERFLOW_EN).
module tb_alu_32bit_serial;

  localparam int W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         ready, busy, done, zero, cout;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_OVERFLOW_EN
  logic         overflow;
`endif

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  alu_32bit_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (a),
    .B        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
`ifdef ALU_SERIAL_OVERFLOW_EN
    .overflow (overflow),
`endif
    .cout     (cout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t    e;
    logic [W:0] s;
    e.res = '0; e.cout = 1'b0; e.ovf = 1'b0;
    case (o)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_ADD: begin
        s      = {1'b0, x} + {1'b0, y};
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      OP_SUB: begin
        s      = {1'b0, x} + {1'b0, ~y} + 1;
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      OP_SLT: begin
        s      = {1'b0, x} + {1'b0, ~y} + 1;
        e.res  = ($signed(x) < $signed(y)) ? 1 : 0;
        e.cout = s[W];
      end
      default: ;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Every done pulse pops one expectation; a done with nothing pending is an error.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("result", result, e.res);
        check_val("zero", zero, e.zero);
        check_val("cout", cout, e.cout);
`ifdef ALU_SERIAL_OVERFLOW_EN
        check_val("overflow", overflow, e.ovf);
`endif
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_it);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (expect_it) sb.push_back(model(o, x, y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns cycles from the accept edge until done is seen, and cycles with ready low.
  task automatic wait_done(output int n, output int low);
    n = 0; low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (!ready) low++;
      if (done) break;
    end
    if (!done) check_val("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n, low;
    issue(o, x, y, 1'b1);
    wait_done(n, low);
    @(negedge clk);
  endtask

  initial begin
    int n, low, d0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_zero", zero, 0);
    check_val("rst_cout", cout, 0);
`ifdef ALU_SERIAL_OVERFLOW_EN
    check_val("rst_overflow", overflow, 0);
`endif

    // OR with latency and ready-window checks
    issue(OP_OR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
    wait_done(n, low);
    check_val("or_latency", n, W + 1);
    check_val("or_ready_low", low, W + 1);
    @(negedge clk);
    check_val("or_ready_back", ready, 1);

    issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    wait_done(n, low);
    check_val("add_ready_low", low, W + 1);
    @(negedge clk);
    check_val("add_ready_back", ready, 1);

    run_op(OP_SUB, 32'd5, 32'd7);
    run_op(OP_SLT, 32'hFFFFFFFF, 32'd1);
    run_op(OP_SLT, 32'd1, 32'hFFFFFFFF);
    run_op(OP_XOR, 32'hA5A5A5A5, 32'h0FF00FF0);
    run_op(OP_ADD, 32'h7FFFFFFF, 32'd1);
    run_op(OP_SUB, 32'h80000000, 32'd1);
    run_op(OP_SUB, 32'h1234, 32'h1234);

    // start pulsed mid-run with different operands must be ignored
    d0 = done_cnt;
    issue(OP_ADD, 32'h00010001, 32'h00020002, 1'b1);
    repeat (6) @(negedge clk);
    op = OP_AND; a = 32'hDEADBEEF; b = 32'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_val("ign_busy", busy, 1);
    wait_done(n, low);
    repeat (3) @(negedge clk);
    check_val("ign_one_done", done_cnt - d0, 1);
    check_val("ign_idle", ready, 1);

    // reset mid-run aborts the op without a done pulse
    d0 = done_cnt;
    issue(OP_ADD, 32'h11111111, 32'h22222222, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_val("abort_ready", ready, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_result", result, 0);
    check_val("abort_done", done, 0);
    repeat (W + 5) @(negedge clk);
    check_val("abort_no_done", done_cnt - d0, 0);
    run_op(OP_AND, 32'h12345678, 32'hFF00FF00);

    // reset and start together: reset wins
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = OP_OR; a = 32'h1; b = 32'h2;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    check_val("rs_ready", ready, 1);
    repeat (W + 5) @(negedge clk);
    check_val("rs_no_done", done_cnt - d0, 0);

    for (int i = 0; i < 16; i++) begin
      logic [2:0] o;
      case ($urandom_range(0, 5))
        0: o = OP_AND;
        1: o = OP_OR;
        2: o = OP_ADD;
        3: o = OP_XOR;
        4: o = OP_SUB;
        default: o = OP_SLT;
      endcase
      run_op(o, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
